// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
//   Shared types and sizing for the sequential restoring divider.
//   DIV_WIDTH   : default divisor / quotient / remainder width
//   div_state_e : divider control states
// -----------------------------------------------------------------------------
package divider_pkg;

    localparam int DIV_WIDTH = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/divider_step.sv
// -----------------------------------------------------------------------------
// divider_step
//   One radix-2 restoring division step (combinational).
//   iRem   : partial remainder R (always < divisor on entry)
//   iQMsb  : MSB of the dividend/quotient shift register, shifted into R
//   iDiv   : divisor D
//   oRem   : next partial remainder
//   oQBit  : quotient bit produced by this step
// -----------------------------------------------------------------------------
module divider_step
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] iRem,
    input  logic             iQMsb,
    input  logic [WIDTH-1:0] iDiv,
    output logic [WIDTH-1:0] oRem,
    output logic             oQBit
);

    logic [WIDTH:0] trial;

    always_comb begin
        trial = {iRem, iQMsb};
        if (trial >= {1'b0, iDiv}) begin
            // trial - D < D, so the difference always fits WIDTH bits and the
            // modular WIDTH-bit subtraction gives the exact result.
            oRem  = trial[WIDTH-1:0] - iDiv;
            oQBit = 1'b1;
        end else begin
            oRem  = trial[WIDTH-1:0];
            oQBit = 1'b0;
        end
    end

endmodule

// File: rtl/divider_256by128_seq.sv
// -----------------------------------------------------------------------------
// divider_256by128_seq
//   Iterative restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
//   one quotient bit per enabled clock. Flags divide-by-zero and quotient
//   overflow without iterating.
//   iClk, iRstN       : clock, async active-low reset
//   iEn               : global enable, low freezes everything
//   iClr              : synchronous clear (dominates iEn)
//   iValid/oReady     : operand handshake, iData0 = dividend, iData1 = divisor
//   oValid/iReady     : result handshake
//   oQuot/oRem        : quotient / remainder
//   oDivZero/oOvf     : divisor was zero / quotient does not fit WIDTH bits
//
//   state | meaning
//   IDLE  | waiting for operands, oReady=1
//   BUSY  | iterating, one quotient bit per enabled edge
//   DONE  | result presented until retired; may accept next operands
// -----------------------------------------------------------------------------
module divider_256by128_seq
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               iClk,
    input  logic               iRstN,
    input  logic               iEn,
    input  logic               iClr,
    input  logic               iValid,
    output logic               oReady,
    input  logic [2*WIDTH-1:0] iData0,
    input  logic [WIDTH-1:0]   iData1,
    output logic               oValid,
    input  logic               iReady,
    output logic [WIDTH-1:0]   oQuot,
    output logic [WIDTH-1:0]   oRem,
    output logic               oDivZero,
    output logic               oOvf
);

    localparam int             CNTW      = $clog2(WIDTH) + 1;
    localparam logic [CNTW-1:0] LAST_ITER = CNTW'(WIDTH - 1);

    div_state_e       state_q, state_d;
    // The partial remainder stays below the divisor, so its (W+1)th bit is
    // always zero and only WIDTH bits are stored.
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             divzero_q, divzero_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] div_hi, div_lo;
    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;
    logic             ready, valid, accept, retire;

    assign div_hi = iData0[2*WIDTH-1:WIDTH];
    assign div_lo = iData0[WIDTH-1:0];

    divider_step #(.WIDTH(WIDTH)) u_step (
        .iRem  (r_q),
        .iQMsb (q_q[WIDTH-1]),
        .iDiv  (d_q),
        .oRem  (step_rem),
        .oQBit (step_qbit)
    );

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        q_d       = q_q;
        d_d       = d_q;
        cnt_d     = cnt_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        divzero_d = divzero_q;
        ovf_d     = ovf_q;

        valid  = (state_q == DONE);
        ready  = (state_q == IDLE) || ((state_q == DONE) && iReady);
        accept = iEn && iValid && ready;
        retire = iEn && valid && iReady;

        case (state_q)
            IDLE: ;
            BUSY: begin
                if (iEn) begin
                    r_d   = step_rem;
                    q_d   = {q_q[WIDTH-2:0], step_qbit};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        state_d = DONE;
                        quot_d  = {q_q[WIDTH-2:0], step_qbit};
                        rem_d   = step_rem;
                    end
                end
            end
            DONE: begin
                if (retire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Accept is only possible in IDLE or DONE; in DONE it overrides the
        // retire-to-IDLE transition for back-to-back operation.
        if (accept) begin
            d_d       = iData1;
            r_d       = div_hi;
            q_d       = div_lo;
            cnt_d     = '0;
            divzero_d = 1'b0;
            ovf_d     = 1'b0;
            if (iData1 == '0) begin
                state_d   = DONE;
                divzero_d = 1'b1;
                quot_d    = '1;
                rem_d     = div_lo;
            end else if (div_hi >= iData1) begin
                state_d = DONE;
                ovf_d   = 1'b1;
                quot_d  = '0;
                rem_d   = '0;
            end else begin
                state_d = BUSY;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q   <= IDLE;
            r_q       <= '0;
            q_q       <= '0;
            d_q       <= '0;
            cnt_q     <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            divzero_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (iClr) begin
            state_q   <= IDLE;
            r_q       <= '0;
            q_q       <= '0;
            d_q       <= '0;
            cnt_q     <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            divzero_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            q_q       <= q_d;
            d_q       <= d_d;
            cnt_q     <= cnt_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            divzero_q <= divzero_d;
            ovf_q     <= ovf_d;
        end
    end

    assign oValid   = valid;
    assign oReady   = ready;
    assign oQuot    = quot_q;
    assign oRem     = rem_q;
    assign oDivZero = divzero_q;
    assign oOvf     = ovf_q;

endmodule

// File: tb/tb_divider_256by128_seq.sv
// -----------------------------------------------------------------------------
// tb_divider_256by128_seq
//   Scoreboard bench: the driver pushes reference results computed with plain
//   256-bit arithmetic, a monitor pops and compares on every result retire.
// -----------------------------------------------------------------------------
module tb_divider_256by128_seq;

    localparam int W     = 128;
    localparam int LIMIT = 2000;

    logic             iClk, iRstN, iEn, iClr, iValid, oReady, oValid, iReady;
    logic [2*W-1:0]   iData0;
    logic [W-1:0]     iData1, oQuot, oRem;
    logic             oDivZero, oOvf;

    divider_256by128_seq #(.WIDTH(W)) dut (
        .iClk     (iClk),
        .iRstN    (iRstN),
        .iEn      (iEn),
        .iClr     (iClr),
        .iValid   (iValid),
        .oReady   (oReady),
        .iData0   (iData0),
        .iData1   (iData1),
        .oValid   (oValid),
        .iReady   (iReady),
        .oQuot    (oQuot),
        .oRem     (oRem),
        .oDivZero (oDivZero),
        .oOvf     (oOvf)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    typedef struct packed {
        logic [W-1:0] quot;
        logic [W-1:0] rem;
        logic         dz;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   retire_cyc[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic exp_t model(input logic [2*W-1:0] a, input logic [W-1:0] b);
        exp_t           e;
        logic [2*W-1:0] bb;
        logic [2*W-1:0] qq;
        logic [2*W-1:0] rr;
        bb = {{W{1'b0}}, b};
        e  = '0;
        if (b == '0) begin
            e.quot = '1;
            e.rem  = a[W-1:0];
            e.dz   = 1'b1;
        end else if (a[2*W-1:W] >= b) begin
            e.ovf = 1'b1;
        end else begin
            qq     = a / bb;
            rr     = a % bb;
            e.quot = qq[W-1:0];
            e.rem  = rr[W-1:0];
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    exp_t mon_e;
    always @(negedge iClk) begin
        if (iRstN && !iClr && iEn && oValid && iReady) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got quot %h with no pending operation", oQuot);
            end else begin
                mon_e = sb.pop_front();
                check("quot", oQuot, mon_e.quot);
                check("rem", oRem, mon_e.rem);
                check("flags", {{(W-2){1'b0}}, oDivZero, oOvf}, {{(W-2){1'b0}}, mon_e.dz, mon_e.ovf});
                retire_cyc.push_back(cyc);
            end
        end
    end

    task automatic send(input logic [2*W-1:0] a, input logic [W-1:0] b);
        int k;
        k      = 0;
        iValid = 1'b1;
        iData0 = a;
        iData1 = b;
        @(negedge iClk);
        while (!(oReady && iEn) && k < LIMIT) begin
            @(negedge iClk);
            k++;
        end
        if (k >= LIMIT) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got oReady=%0d expected 1", oReady);
        end else begin
            sb.push_back(model(a, b));
        end
        @(posedge iClk);
        #1;
        iValid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!oValid && n < LIMIT) begin
            @(posedge iClk);
            #1;
            n++;
        end
        if (n >= LIMIT) begin
            n_checks++;
            n_fail++;
            $display("FAIL valid_timeout: got oValid=%0d expected 1", oValid);
        end
    endtask

    task automatic roundtrip(output logic [2*W-1:0] p, output logic [W-1:0] b, output logic [W-1:0] a);
        a = rnd128();
        b = rnd128() >> $urandom_range(0, W - 1);
        if (a == '0) a = 1;
        if (b == '0) b = 1;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge iClk);
            #1;
        end
    endtask

    logic [2*W-1:0] p;
    logic [W-1:0]   a, b;
    int             lat;

    initial begin
        iRstN  = 1'b0;
        iEn    = 1'b1;
        iClr   = 1'b0;
        iValid = 1'b0;
        iReady = 1'b1;
        iData0 = '0;
        iData1 = '0;
        step(3);
        iRstN = 1'b1;
        step(1);

        check("rst_ready", W'(oReady), W'(1));
        check("rst_valid", W'(oValid), W'(0));
        check("rst_quot", oQuot, '0);
        check("rst_rem", oRem, '0);
        check("rst_flags", W'({oDivZero, oOvf}), W'(0));

        // Known small divide and its latency.
        send(256'd1000, 128'd7);
        wait_valid(lat);
        check("lat_normal", W'(lat), W'(W));
        check("known_quot", oQuot, 128'd142);
        step(1);

        // Overflow: hi half equals divisor.
        send('1, '1);
        wait_valid(lat);
        check("lat_ovf", W'(lat), W'(0));
        step(1);

        // Divide by zero.
        send(256'd5, '0);
        wait_valid(lat);
        check("lat_dz", W'(lat), W'(0));
        check("dz_quot", oQuot, '1);
        step(1);

        // Random roundtrips.
        for (int i = 0; i < 4; i++) begin
            roundtrip(p, b, a);
            send(p, b);
            wait_valid(lat);
            check("lat_rt", W'(lat), W'(W));
            step(1);
        end

        // Stall 10 cycles mid-BUSY, then hold the result with iReady low.
        roundtrip(p, b, a);
        iReady = 1'b0;
        send(p, b);
        step(40);
        iEn = 1'b0;
        step(10);
        check("stall_busy_valid", W'(oValid), W'(0));
        iEn = 1'b1;
        wait_valid(lat);
        check("lat_stall", W'(lat), W'(W - 40));
        step(5);
        check("hold_valid", W'(oValid), W'(1));
        check("hold_quot", oQuot, a);
        check("hold_ready", W'(oReady), W'(0));
        iReady = 1'b1;
        step(1);
        check("retire_idle", W'(oValid), W'(0));

        // Synchronous clear mid-operation.
        roundtrip(p, b, a);
        send(p, b);
        step(49);
        iClr = 1'b1;
        step(1);
        iClr = 1'b0;
        void'(sb.pop_back());
        check("clr_valid", W'(oValid), W'(0));
        check("clr_ready", W'(oReady), W'(1));
        check("clr_quot", oQuot, '0);
        step(W + 5);
        check("clr_no_result", W'(oValid), W'(0));
        roundtrip(p, b, a);
        send(p, b);
        wait_valid(lat);
        check("lat_after_clr", W'(lat), W'(W));
        step(1);

        // Asynchronous reset mid-operation.
        roundtrip(p, b, a);
        send(p, b);
        step(49);
        #2;
        iRstN = 1'b0;
        #1;
        void'(sb.pop_back());
        check("arst_valid", W'(oValid), W'(0));
        check("arst_ready", W'(oReady), W'(1));
        step(1);
        iRstN = 1'b1;
        step(1);
        roundtrip(p, b, a);
        send(p, b);
        wait_valid(lat);
        check("lat_after_rst", W'(lat), W'(W));
        step(1);

        // Back-to-back roundtrips: consecutive retires exactly W+1 edges apart.
        retire_cyc.delete();
        for (int i = 0; i < 20; i++) begin
            roundtrip(p, b, a);
            send(p, b);
        end
        wait_valid(lat);
        step(1);
        check("b2b_count", W'(retire_cyc.size()), W'(20));
        for (int i = 1; i < retire_cyc.size(); i++) begin
            check("b2b_gap", W'(retire_cyc[i] - retire_cyc[i-1]), W'(W + 1));
        end

        // Mixed random operands, including overflow and zero divisors.
        for (int i = 0; i < 12; i++) begin
            p = {rnd128() >> $urandom_range(0, W), rnd128()};
            b = ($urandom_range(0, 5) == 0) ? '0 : rnd128();
            send(p, b);
        end
        wait_valid(lat);
        step(2);

        check("sb_empty", W'(sb.size()), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
